// File: rtl/hex_scroll_ctrl.sv
// Rotation-select sequencer for the 4-digit "0dE1" 7-segment decoder.
// Auto-scrolls at a switch-selected rate or single-steps from a debounced pushbutton.
module hex_scroll_ctrl #(
  parameter int DIV_SLOW     = 50_000_000,
  parameter int DIV_FAST     = 12_500_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       KEY_RUN,
  input  logic       KEY_STEP,
  input  logic       SW_DIR,
  input  logic       SW_FAST,
  output logic [1:0] SEL,
  output logic       SEL_UPD,
  output logic       RUNNING
);

  localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int CW      = $clog2(DIV_MAX + 1);
  localparam int DW      = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] SLOW_M1 = CW'(DIV_SLOW - 1);
  localparam logic [CW-1:0] FAST_M1 = CW'(DIV_FAST - 1);
  localparam logic [DW-1:0] DEB_M1  = DW'(DEBOUNCE_CYC - 1);

  typedef enum logic {STOP, RUN} state_t;

  state_t             state, state_nxt;
  logic [1:0]         key_meta, key_sync, key_deb, key_press;
  logic [1:0][DW-1:0] deb_cnt;
  logic [1:0]         sw_meta, sw_sync;
  logic               run_press, step_press, dir, fast;
  logic [CW-1:0]      cnt, div_m1;
  logic               tick, advance, cnt_clr, cnt_inc;

  // Bit 0 carries the run key, bit 1 the step key; a key's accepted level only
  // follows the synced input after DEBOUNCE_CYC consecutive differing samples.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      key_meta  <= 2'b11;
      key_sync  <= 2'b11;
      key_deb   <= 2'b11;
      key_press <= 2'b00;
      deb_cnt   <= '0;
      sw_meta   <= 2'b00;
      sw_sync   <= 2'b00;
    end else begin
      key_meta <= {KEY_STEP, KEY_RUN};
      key_sync <= key_meta;
      sw_meta  <= {SW_FAST, SW_DIR};
      sw_sync  <= sw_meta;
      for (int i = 0; i < 2; i++) begin
        key_press[i] <= 1'b0;
        if (key_sync[i] == key_deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_M1) begin
          deb_cnt[i]   <= '0;
          key_deb[i]   <= key_sync[i];
          key_press[i] <= ~key_sync[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign run_press  = key_press[0];
  assign step_press = key_press[1];
  assign dir        = sw_sync[0];
  assign fast       = sw_sync[1];

  // Using >= lets a switch to the fast rate fire immediately when the count
  // is already beyond the shorter period.
  assign div_m1 = fast ? FAST_M1 : SLOW_M1;
  assign tick   = (cnt >= div_m1);

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) state <= STOP;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      STOP:    if (run_press) state_nxt = RUN;
      RUN:     if (run_press) state_nxt = STOP;
      default: state_nxt = STOP;
    endcase
  end

  // A run press always wins: it suppresses a coincident step or tick.
  always_comb begin
    advance = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    RUNNING = (state == RUN);
    case (state)
      STOP: begin
        if (run_press)       cnt_clr = 1'b1;
        else if (step_press) advance = 1'b1;
      end
      RUN: begin
        if (!run_press) begin
          if (tick) begin
            advance = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      cnt     <= '0;
      SEL     <= 2'd0;
      SEL_UPD <= 1'b0;
    end else begin
      SEL_UPD <= advance;
      if (advance) SEL <= dir ? SEL - 2'd1 : SEL + 2'd1;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Self-checking bench for hex_scroll_ctrl: step table, directed timing sequences,
// and random key/switch activity compared each cycle against a behavioural model.
module tb_hex_scroll_ctrl;

  localparam int DIV_SLOW = 10;
  localparam int DIV_FAST = 3;
  localparam int DEB      = 4;

  logic       CLOCK_50 = 1'b0;
  logic       RESET    = 1'b1;
  logic       KEY_RUN  = 1'b1;
  logic       KEY_STEP = 1'b1;
  logic       SW_DIR   = 1'b0;
  logic       SW_FAST  = 1'b0;
  logic [1:0] SEL;
  logic       SEL_UPD;
  logic       RUNNING;

  int tests  = 0;
  int fails  = 0;
  bit mon_en = 1'b0;

  typedef struct {
    bit run_key;
    bit step_key;
    bit dir;
    int hold;
    int exp_sel;
    int exp_upd;
    int exp_running;
  } vec_t;

  hex_scroll_ctrl #(
    .DIV_SLOW    (DIV_SLOW),
    .DIV_FAST    (DIV_FAST),
    .DEBOUNCE_CYC(DEB)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET   (RESET),
    .KEY_RUN (KEY_RUN),
    .KEY_STEP(KEY_STEP),
    .SW_DIR  (SW_DIR),
    .SW_FAST (SW_FAST),
    .SEL     (SEL),
    .SEL_UPD (SEL_UPD),
    .RUNNING (RUNNING)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Reference model: inputs reach the logic two clocks late (queue), keys change
  // accepted level after DEB consecutive opposite samples, events act one clock later.
  logic [3:0] rawq[$] = '{4'b0011, 4'b0011};
  int m_sel = 0, m_upd = 0, m_running = 0, m_count = 0;
  int m_acc[2] = '{1, 1};
  int m_run[2] = '{0, 0};
  bit m_ev[2]  = '{1'b0, 1'b0};

  task automatic modelStep();
    logic [3:0] seen;
    int div;
    if (RESET) begin
      rawq = '{4'b0011, 4'b0011};
      m_sel = 0; m_upd = 0; m_running = 0; m_count = 0;
      m_acc = '{1, 1}; m_run = '{0, 0}; m_ev = '{1'b0, 1'b0};
    end else begin
      seen = rawq.pop_front();
      rawq.push_back({SW_FAST, SW_DIR, KEY_STEP, KEY_RUN});
      div   = seen[3] ? DIV_FAST : DIV_SLOW;
      m_upd = 0;
      if (m_running == 0) begin
        if (m_ev[0]) begin m_running = 1; m_count = 0; end
        else if (m_ev[1]) m_upd = 1;
      end else begin
        if (m_ev[0]) m_running = 0;
        else if (m_count >= div - 1) begin m_upd = 1; m_count = 0; end
        else m_count++;
      end
      if (m_upd == 1) m_sel = seen[2] ? (m_sel + 3) % 4 : (m_sel + 1) % 4;
      for (int i = 0; i < 2; i++) begin
        m_ev[i] = 1'b0;
        if (int'(seen[i]) != m_acc[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_acc[i] = int'(seen[i]);
            m_run[i] = 0;
            m_ev[i]  = (seen[i] == 1'b0);
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge CLOCK_50 or posedge RESET);
    modelStep();
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge CLOCK_50);
    if (mon_en && !RESET) begin
      checkOutput("mon_sel", int'(SEL), m_sel);
      checkOutput("mon_upd", int'(SEL_UPD), m_upd);
      checkOutput("mon_running", int'(RUNNING), m_running);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic doReset();
    RESET = 1'b1; KEY_RUN = 1'b1; KEY_STEP = 1'b1; SW_DIR = 1'b0; SW_FAST = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    RESET = 1'b0;
    @(negedge CLOCK_50);
  endtask

  task automatic cyclesToUpd(input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge CLOCK_50);
      if (SEL_UPD) begin n = i; break; end
    end
  endtask

  task automatic waitRunning(input logic level, input int bound, output int n, output int upds);
    n = -1;
    upds = 0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge CLOCK_50);
      if (SEL_UPD) upds++;
      if (RUNNING == level) begin n = i; break; end
    end
  endtask

  task automatic countUpds(input int cycles, output int upds);
    upds = 0;
    repeat (cycles) begin
      @(negedge CLOCK_50);
      if (SEL_UPD) upds++;
    end
  endtask

  task automatic applyStimulus(input vec_t v, output int upds);
    SW_DIR   = v.dir;
    KEY_RUN  = ~v.run_key;
    KEY_STEP = ~v.step_key;
    upds = 0;
    repeat (v.hold) begin
      @(negedge CLOCK_50);
      if (SEL_UPD) upds++;
    end
    KEY_RUN  = 1'b1;
    KEY_STEP = 1'b1;
    repeat (12) begin
      @(negedge CLOCK_50);
      if (SEL_UPD) upds++;
    end
  endtask

  initial begin
    vec_t vecs[8];
    int n, u, exp_sel, high_cnt;

    vecs[0] = '{0, 1, 0,  8, 1, 1, 0};
    vecs[1] = '{0, 1, 0,  8, 2, 1, 0};
    vecs[2] = '{0, 1, 0,  8, 3, 1, 0};
    vecs[3] = '{0, 1, 0,  8, 0, 1, 0};
    vecs[4] = '{0, 1, 1,  8, 3, 1, 0};
    vecs[5] = '{0, 1, 1,  3, 3, 0, 0};
    vecs[6] = '{0, 1, 1, 40, 2, 1, 0};
    vecs[7] = '{0, 1, 0,  8, 3, 1, 0};

    // Reset state
    repeat (2) @(negedge CLOCK_50);
    checkOutput("reset_sel", int'(SEL), 0);
    checkOutput("reset_upd", int'(SEL_UPD), 0);
    checkOutput("reset_running", int'(RUNNING), 0);
    RESET = 1'b0;
    mon_en = 1'b1;
    @(negedge CLOCK_50);

    // Async reset in the middle of RUN at SEL=2
    KEY_RUN = 1'b0;
    waitRunning(1'b1, 20, n, u);
    checkOutput("t1_run_lat", n, 7);
    KEY_RUN = 1'b1;
    cyclesToUpd(20, n);
    checkOutput("t1_gap1", n, DIV_SLOW);
    cyclesToUpd(20, n);
    checkOutput("t1_gap2", n, DIV_SLOW);
    checkOutput("t1_sel_before", int'(SEL), 2);
    repeat (4) @(negedge CLOCK_50);
    RESET = 1'b1;
    #1;
    checkOutput("t1_sel_rst", int'(SEL), 0);
    checkOutput("t1_running_rst", int'(RUNNING), 0);
    checkOutput("t1_upd_rst", int'(SEL_UPD), 0);
    repeat (2) @(negedge CLOCK_50);
    RESET = 1'b0;
    countUpds(50, u);
    checkOutput("t1_no_adv", u, 0);
    checkOutput("t1_sel_after", int'(SEL), 0);

    // Single-step table
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], u);
      checkOutput($sformatf("vec%0d_sel", i), int'(SEL), vecs[i].exp_sel);
      checkOutput($sformatf("vec%0d_upd", i), u, vecs[i].exp_upd);
      checkOutput($sformatf("vec%0d_running", i), int'(RUNNING), vecs[i].exp_running);
    end

    // Slow run, then switch to fast with count at 5 (7 once synced)
    doReset();
    KEY_RUN = 1'b0;
    waitRunning(1'b1, 20, n, u);
    checkOutput("t3_run_rise", n, 7);
    KEY_RUN = 1'b1;
    exp_sel = 0;
    for (int k = 0; k < 4; k++) begin
      cyclesToUpd(20, n);
      exp_sel = (exp_sel + 1) % 4;
      checkOutput($sformatf("t3_gap%0d", k), n, DIV_SLOW);
      checkOutput($sformatf("t3_sel%0d", k), int'(SEL), exp_sel);
    end
    repeat (5) @(negedge CLOCK_50);
    SW_FAST = 1'b1;
    cyclesToUpd(10, n);
    checkOutput("t4_first_fast", n, 3);
    for (int k = 0; k < 2; k++) begin
      cyclesToUpd(10, n);
      checkOutput($sformatf("t4_fast_gap%0d", k), n, DIV_FAST);
    end
    SW_FAST = 1'b0;

    // Collisions: run+step in STOP, then run press on the tick cycle
    doReset();
    KEY_RUN = 1'b0;
    KEY_STEP = 1'b0;
    waitRunning(1'b1, 20, n, u);
    checkOutput("t6_run_rise", n, 7);
    checkOutput("t6_step_dropped", u, 0);
    checkOutput("t6_sel_kept", int'(SEL), 0);
    KEY_RUN = 1'b1;
    KEY_STEP = 1'b1;
    cyclesToUpd(20, n);
    checkOutput("t6_first_tick", n, DIV_SLOW);
    checkOutput("t6_sel1", int'(SEL), 1);
    repeat (3) @(negedge CLOCK_50);
    KEY_RUN = 1'b0;
    waitRunning(1'b0, 15, n, u);
    checkOutput("t6_stop_lat", n, 7);
    checkOutput("t6_tick_dropped", u, 0);
    checkOutput("t6_sel_stop", int'(SEL), 1);
    KEY_RUN = 1'b1;
    countUpds(30, u);
    checkOutput("t6_stopped", u, 0);

    // Bouncing run key: 20 cycles of 2-cycle toggles, then held low
    doReset();
    high_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      KEY_RUN = 1'b0;
      repeat (2) begin @(negedge CLOCK_50); if (RUNNING) high_cnt++; end
      KEY_RUN = 1'b1;
      repeat (2) begin @(negedge CLOCK_50); if (RUNNING) high_cnt++; end
    end
    checkOutput("t5_no_early", high_cnt, 0);
    KEY_RUN = 1'b0;
    waitRunning(1'b1, 15, n, u);
    checkOutput("t5_run_lat", n, 7);
    high_cnt = 0;
    repeat (20) begin @(negedge CLOCK_50); if (RUNNING) high_cnt++; end
    checkOutput("t5_single_event", high_cnt, 20);
    KEY_RUN = 1'b1;

    // Random keys and switches against the model
    doReset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLOCK_50);
      if ($urandom_range(0, 11) == 0) KEY_RUN  = ~KEY_RUN;
      if ($urandom_range(0, 9)  == 0) KEY_STEP = ~KEY_STEP;
      if ($urandom_range(0, 49) == 0) SW_DIR   = ~SW_DIR;
      if ($urandom_range(0, 49) == 0) SW_FAST  = ~SW_FAST;
    end
    KEY_RUN = 1'b1;
    KEY_STEP = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
